// File: rtl/ins_loader_pkg.sv
// Shared state encoding and load-format constants
// for the instruction memory loader.
`timescale 1ns/1ps
package ins_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/ins_loader.sv
// Byte-stream instruction loader: 16-bit LE word count
// header, then LE 32-bit words written to imem.
`timescale 1ns/1ps
module ins_loader
  import ins_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wa,
  output logic [DATA_WIDTH-1:0] wd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE =
    {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t state_q, state_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [7:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic [DATA_WIDTH-1:0] word_nx;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH:0] n_q, n_d;
  logic [ADDR_WIDTH:0] cnt_inc;
  logic err_q, err_d;
  logic take, last_hdr, last_byte, oversize;
  logic [15:0] hdr_w;

  assign byte_ready = (state_q == HDR) ||
                      (state_q == DATA);
  assign take = byte_valid & byte_ready;
  assign hdr_w = {byte_data, lo_q};
  assign oversize = {1'b0, hdr_w} > 17'(DEPTH);
  assign word_nx = {byte_data, word_q[DATA_WIDTH-1:8]};
  assign last_hdr = bcnt_q == 2'(HDR_BYTES - 1);
  assign last_byte = bcnt_q == 2'(WORD_BYTES - 1);
  assign cnt_inc = cnt_q + ONE;

  assign we = state_q == WRITE;
  assign busy = (state_q == HDR) ||
                (state_q == DATA) ||
                (state_q == WRITE);
  assign done = state_q == FIN;
  assign err = err_q;
  assign wa = wa_q;
  assign wd = wd_q;

  // Next state: header parse, word assembly, write, finish.
  always_comb begin
    state_d = state_q;
    bcnt_d = bcnt_q;
    lo_d = lo_q;
    word_d = word_q;
    wd_d = wd_q;
    wa_d = wa_q;
    cnt_d = cnt_q;
    n_d = n_q;
    err_d = err_q;
    unique case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = HDR;
          err_d = 1'b0;
          bcnt_d = '0;
          cnt_d = '0;
        end
      end
      HDR: begin
        if (take) begin
          if (!last_hdr) begin
            lo_d = byte_data;
            bcnt_d = bcnt_q + 2'd1;
          end else begin
            bcnt_d = '0;
            if (hdr_w == 16'd0) begin
              state_d = FIN;
            end else begin
              state_d = DATA;
              err_d = oversize;
              n_d = oversize ? DEPTH
                             : hdr_w[ADDR_WIDTH:0];
            end
          end
        end
      end
      DATA: begin
        if (take) begin
          word_d = word_nx;
          if (last_byte) begin
            bcnt_d = '0;
            wd_d = word_nx;
            wa_d = cnt_q[ADDR_WIDTH-1:0];
            state_d = WRITE;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      WRITE: begin
        cnt_d = cnt_inc;
        state_d = (cnt_inc == n_q) ? FIN : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q <= '0;
      lo_q <= '0;
      word_q <= '0;
      wd_q <= '0;
      wa_q <= '0;
      cnt_q <= '0;
      n_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q <= bcnt_d;
      lo_q <= lo_d;
      word_q <= word_d;
      wd_q <= wd_d;
      wa_q <= wa_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Randomized bench for ins_loader with a byte-stream
// reference model and per-cycle output comparison.
`timescale 1ns/1ps
module tb_ins_loader;

  localparam int AW = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic byte_ready, we, busy, done, err;
  logic [AW-1:0] wa;
  logic [31:0] wd;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  logic [AW-1:0] log_a[$];
  logic [31:0] log_d[$];
  logic [7:0] stim[$];

  ins_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .we(we),
    .wa(wa),
    .wd(wd),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, want %0h",
               nm, $time, act, exp);
    end
  endtask

  // Reference model: expected outputs derived from the
  // count of accepted stream bytes and completed writes.
  bit e_we = 0, e_busy = 0, e_done = 0;
  bit e_err = 0, e_ready = 0;
  logic [AW-1:0] e_wa = '0;
  logic [31:0] e_wd = '0;
  logic [31:0] m_word = '0;
  logic [7:0] m_lo = '0;
  int m_acc = 0, m_n = 0, m_wr = 0;

  always @(posedge clk) begin : model
    bit take;
    int hn;
    logic [31:0] w;
    take = byte_valid && e_ready;
    w = {byte_data, m_word[31:8]};
    if (rst) begin
      e_we <= 0; e_busy <= 0; e_done <= 0;
      e_err <= 0; e_ready <= 0;
      e_wa <= '0; e_wd <= '0;
      m_acc <= 0; m_wr <= 0;
    end else if (!e_busy && start) begin
      e_busy <= 1; e_ready <= 1;
      e_done <= 0; e_err <= 0;
      m_acc <= 0; m_wr <= 0;
    end else if (e_we) begin
      e_we <= 0;
      m_wr <= m_wr + 1;
      if (m_wr + 1 == m_n) begin
        e_busy <= 0; e_done <= 1; e_ready <= 0;
      end else begin
        e_ready <= 1;
      end
    end else if (take) begin
      m_acc <= m_acc + 1;
      if (m_acc == 0) begin
        m_lo <= byte_data;
      end else if (m_acc == 1) begin
        hn = int'({byte_data, m_lo});
        if (hn == 0) begin
          e_busy <= 0; e_done <= 1; e_ready <= 0;
        end else begin
          m_n <= (hn > DEPTH) ? DEPTH : hn;
          e_err <= hn > DEPTH;
        end
      end else begin
        m_word <= w;
        if ((m_acc - 2) % 4 == 3) begin
          e_we <= 1; e_ready <= 0;
          e_wa <= AW'((m_acc - 2) / 4);
          e_wd <= w;
        end
      end
    end
  end

  // Per-cycle comparison of every output to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", we, e_we);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("byte_ready", byte_ready, e_ready);
      chk("wa", wa, e_wa);
      chk("wd", wd, e_wd);
    end
  end

  // Record every memory write for end-of-load checks.
  always @(negedge clk) begin
    if (we) begin
      log_a.push_back(wa);
      log_d.push_back(wd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap,
                           input int bound,
                           output bit ok);
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data = b;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (byte_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_q(input int gmin, input int gmax);
    bit ok;
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], $urandom_range(gmin, gmax),
                50, ok);
      chk("accept", ok, 1);
    end
  endtask

  task automatic wait_done(input string nm,
                           input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done) break;
      tick();
    end
    chk(nm, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin : stim_proc
    bit ok;
    int n;
    logic [31:0] exp_w;
    logic [31:0] last_w;

    tick();
    tick();
    chk_en = 1'b1;
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_wa", wa, 0);
    chk("rst_wd", wd, 0);
    rst = 1'b0;
    tick();

    // Basic two-word load.
    log_a.delete(); log_d.delete();
    stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    send_q(0, 2);
    wait_done("basic_done", 20);
    chk("basic_err", err, 0);
    chk("basic_nwr", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("basic_a0", log_a[0], 0);
      chk("basic_d0", log_d[0], 32'h12345678);
      chk("basic_a1", log_a[1], 1);
      chk("basic_d1", log_d[1], 32'hDEADBEEF);
    end

    // Empty load.
    log_a.delete(); log_d.delete();
    stim = '{8'h00, 8'h00};
    pulse_start();
    send_q(0, 0);
    chk("empty_done", done, 1);
    repeat (3) tick();
    chk("empty_nwr", log_a.size(), 0);

    // Oversized header: N = 1025.
    log_a.delete(); log_d.delete();
    stim = '{8'h01, 8'h04};
    pulse_start();
    send_q(0, 0);
    chk("ovf_err_early", err, 1);
    last_w = '0;
    for (int w = 0; w < DEPTH; w++) begin
      stim.delete();
      for (int k = 0; k < 4; k++)
        stim.push_back(8'($urandom));
      last_w = {stim[3], stim[2], stim[1], stim[0]};
      send_q(0, 0);
    end
    send_byte(8'h5A, 0, 20, ok);
    chk("ovf_extra_byte", ok, 0);
    chk("ovf_ready", byte_ready, 0);
    chk("ovf_err", err, 1);
    chk("ovf_done", done, 1);
    chk("ovf_nwr", log_a.size(), DEPTH);
    if (log_a.size() == DEPTH) begin
      chk("ovf_last_a", log_a[DEPTH-1], DEPTH - 1);
      chk("ovf_last_d", log_d[DEPTH-1], last_w);
    end

    // Reset in the middle of a word.
    log_a.delete(); log_d.delete();
    stim = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    pulse_start();
    send_q(0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("rstmid_busy", busy, 0);
    chk("rstmid_nwr0", log_a.size(), 0);
    stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    send_q(0, 1);
    wait_done("rstmid_done", 20);
    chk("rstmid_nwr", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("rstmid_a", log_a[0], 0);
      chk("rstmid_d", log_d[0], 32'h44332211);
    end

    // Stalls with start pulsed while busy.
    log_a.delete(); log_d.delete();
    stim = '{8'h01, 8'h00};
    pulse_start();
    send_q(1, 1);
    pulse_start();
    stim = '{8'hC3, 8'hB2};
    send_q(1, 1);
    pulse_start();
    stim = '{8'hA1, 8'h90};
    send_q(1, 1);
    chk("stall_we_lat", we, 1);
    wait_done("stall_done", 20);
    chk("stall_nwr", log_a.size(), 1);
    if (log_a.size() == 1)
      chk("stall_d", log_d[0], 32'h90A1B2C3);

    // Random loads with random gaps.
    for (int r = 0; r < 4; r++) begin
      log_a.delete(); log_d.delete();
      n = $urandom_range(1, 6);
      stim.delete();
      stim.push_back(8'(n));
      stim.push_back(8'h00);
      for (int k = 0; k < 4 * n; k++)
        stim.push_back(8'($urandom));
      pulse_start();
      send_q(0, 3);
      wait_done("rnd_done", 20);
      chk("rnd_err", err, 0);
      chk("rnd_nwr", log_a.size(), n);
      for (int k = 0; k < n && k < log_d.size(); k++) begin
        exp_w = {stim[4*k+5], stim[4*k+4],
                 stim[4*k+3], stim[4*k+2]};
        chk("rnd_a", log_a[k], k);
        chk("rnd_d", log_d[k], exp_w);
      end
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: instruction word width; the load format below fixes it at 32.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: instruction memory address width; memory depth is 2**ADDR_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a load.
REQ-006 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid byte.
REQ-007 SHALL have port byte_data, input, 8 bits: load stream byte.
REQ-008 SHALL have port byte_ready, output, 1 bit: the loader can accept a byte this cycle.
REQ-009 SHALL have port we, output, 1 bit: instruction memory write enable.
REQ-010 SHALL have port wa, output, ADDR_WIDTH bits: instruction memory write address.
REQ-011 SHALL have port wd, output, DATA_WIDTH bits: instruction memory write data.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress; the CPU is held off memory.
REQ-013 SHALL have port done, output, 1 bit: the last load completed.
REQ-014 SHALL have port err, output, 1 bit: the last load's header exceeded memory depth.

Function
REQ-015 SHALL implement the states IDLE, HDR, DATA, WRITE and FIN.
REQ-016 SHALL accept a byte only in a cycle where byte_valid and byte_ready are both 1.
REQ-017 SHALL drive byte_ready to 1 only in HDR and DATA.
REQ-018 SHALL, in IDLE or FIN, on start=1: go to HDR, clear done and err, zero the address and byte counters, and set busy=1 from the next cycle.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL take the header as 2 bytes, little-endian: a 16-bit word count N.
REQ-021 SHALL, after the header, go to FIN if N=0, otherwise to DATA.
REQ-022 SHALL, if N > 2**ADDR_WIDTH, set err=1 and load exactly 2**ADDR_WIDTH words.
  - Any bytes beyond that are not consumed.
REQ-023 SHALL assemble each word from 4 bytes, little-endian: the first byte goes to wd[7:0], the fourth to wd[31:24].
REQ-024 SHALL go to WRITE on acceptance of the 4th byte; in WRITE we=1 for exactly one cycle, with wa = current address and wd = the assembled word.
REQ-025 SHALL enforce write latency: 4th byte accepted at edge t gives we=1 in the cycle after edge t.
REQ-026 SHALL, after WRITE, increment the address and return to DATA, or go to FIN after the last word.
REQ-027 SHALL, in FIN, hold busy=0 and done=1 until the next start or rst.
REQ-028 SHALL drive we=0 in every state except WRITE; wa and wd are don't-care when we=0 but are held stable.
REQ-029 SHALL never let the address counter wrap: the last write address is 2**ADDR_WIDTH-1 at most.
REQ-030 SHALL tolerate byte_valid gaps of any length without changing state or partial-word contents.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter IDLE regardless of state, including mid-word and during WRITE.
REQ-032 SHALL, on reset, drive we=0, busy=0, done=0, err=0, byte_ready=0, wa=0 and wd=0, and clear all counters.
REQ-033 SHALL discard any partially assembled word on reset; no write may follow reset without a new start.

Structure
REQ-034 SHALL place the state encoding (IDLE/HDR/DATA/WRITE/FIN), the header byte count (2) and the bytes-per-word constant (4) in a shared package.
REQ-035 SHALL be a single module with no sub-modules.
  - The memory it writes is a separate writable instruction memory instantiated by the parent.

Verification
REQ-036 SHALL cover a basic load: start; bytes 02 00, 78 56 34 12, EF BE AD DE.
  - Required: writes 0x12345678@0 then 0xDEADBEEF@1; done=1, err=0.
REQ-037 SHALL cover an empty load: start; header 00 00.
  - Required: no we pulse; done=1 two accepted bytes after start.
REQ-038 SHALL cover an oversized header: start; header 01 04 (N=1025); stream 1025 words.
  - Required: 1024 writes, last at wa=1023; err=1; byte_ready=0 after word 1024.
REQ-039 SHALL cover reset mid-word: start; header 01 00; bytes AA BB; rst=1 for 1 cycle; then start; 01 00; 11 22 33 44.
  - Required: exactly one write, 0x44332211@0.
REQ-040 SHALL cover stalls and ignored start: 01 00 header, byte_valid toggled every other cycle, start pulsed while busy.
  - Required: one correct write; load not restarted; we exactly one cycle after the 4th accepted byte.
